perm_iter: RTL and testbench
============================

PERM_ITER -- requirements
Module: perm_iter

Interface
REQ-001 SHALL have port clock_i, input, 1 bit, single system clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_i, input, 1 bit, reset, synchronous and active-high.
REQ-003 SHALL have port start_i, input, 1 bit, request to start a permutation, sampled on the rising edge.
REQ-004 SHALL have port mode_i, input, 1 bit, permutation length: 0 = p^a (12 rounds), 1 = p^b (6 rounds); sampled with start_i.
REQ-005 SHALL have port state_i, input, type_state (5 x 64 bits), permutation input; sampled with start_i.
REQ-006 SHALL have port state_o, output, type_state, current content of the internal state register.
REQ-007 SHALL have port round_o, output, 4 bits, round index applied on the next edge while busy; drives the round input of the constant-addition stage.
REQ-008 SHALL have port busy_o, output, 1 bit, high while rounds are executing.
REQ-009 SHALL have port done_o, output, 1 bit, one-cycle pulse when state_o holds a finished permutation.

Function
REQ-010 SHALL implement FSM states IDLE, RUN and DONE.
REQ-011 SHALL, in IDLE or DONE with start_i=1, load state_i into the state register, load round counter with 0 (mode_i=0) or 6 (mode_i=1), and go to RUN.
REQ-012 SHALL, in RUN, each edge replace the state register with pl(ps(pc(state, round))) and increment the round counter by 1.
REQ-013 SHALL leave RUN for DONE on the edge that applies round 11; p^a therefore completes 12 edges after the start edge and p^b 6 edges after it.
REQ-014 SHALL assert done_o only in DONE and hold DONE for exactly one cycle, then go to IDLE unless start_i=1, which is accepted per REQ-011 (back-to-back operation).
REQ-015 SHALL ignore start_i, mode_i and state_i while in RUN; there is no abort other than reset.
REQ-016 SHALL hold the state register unchanged in IDLE and DONE, so the result stays readable on state_o until the next accepted start.
REQ-017 SHALL drive busy_o = 1 exactly in RUN and round_o = round counter at all times (0 in IDLE after reset).
REQ-018 SHALL never allow the round counter outside 0..11; the 4-bit value does not wrap during legal operation.

Reset
REQ-019 SHALL, on reset_i=1 at a rising edge, enter IDLE, clear the state register to all zeros, clear the round counter to 0, and deassert busy_o and done_o, with priority over start_i.
REQ-020 SHALL, on reset during RUN or DONE, discard the in-flight permutation and produce no done_o pulse for it.

Structure
REQ-021 SHALL take type_state from ascon_pack and add there: ROUND_FIRST_A = 0, ROUND_FIRST_B = 6, ROUND_LAST = 11, and the FSM state enum type.
REQ-022 SHALL place the combinational round in one sub-module, perm_round (state_i, round_i, state_o), which chains the existing pc, ps and pl stages; perm_iter holds only the FSM, round counter and state register.

Verification
REQ-023 Reset: assert reset_i for 2 cycles with start_i=1 -> state_o = 0, round_o = 0, busy_o = 0, done_o = 0; FSM stays IDLE.
REQ-024 p^a: state_i = {80400c0600000000, 0001020304050607, 08090a0b0c0d0e0f, 0011223344556677, 8899aabbccddeeff}, mode_i=0, start pulse -> round_o steps 0..11; busy_o high for 12 cycles; done_o pulses 12 edges after the start edge; state_o equals the golden-model p^a output.
REQ-025 p^b: same input, mode_i=1 -> round_o steps 6..11; done_o pulses 6 edges after the start edge; state_o equals the golden-model p^b output.
REQ-026 Start during RUN: pulse start_i with different state_i at round 3 -> no effect; the result matches REQ-024.
REQ-027 Back-to-back: start_i=1 in the DONE cycle with mode_i=1 -> no IDLE cycle; RUN resumes with round_o=6 and the new state_i.
REQ-028 Mid-run reset: reset_i at round 5 of p^a -> IDLE next cycle, state_o = 0, and no done_o pulse appears afterwards.

Source files
------------

// File: rtl/ascon_pack.sv
// Shared Ascon types plus the three permutation stages (constant addition,
// substitution, linear diffusion) and the round-sequencing constants.
package ascon_pack;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } type_state;

  localparam logic [3:0] ROUND_FIRST_A = 4'd0;
  localparam logic [3:0] ROUND_FIRST_B = 4'd6;
  localparam logic [3:0] ROUND_LAST    = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } perm_fsm_t;

  function automatic logic [63:0] ror64(input logic [63:0] x, input logic [6:0] n);
    return (x >> n) | (x << (7'd64 - n));
  endfunction

  // Round constant is {15-r, r}; p^b reuses the tail of the p^a sequence.
  function automatic type_state pc(input type_state s, input logic [3:0] round);
    type_state r;
    r    = s;
    r.x2 = s.x2 ^ {56'd0, (4'd15 - round), round};
    return r;
  endfunction

  function automatic type_state ps(input type_state s);
    logic [63:0] a, b, c, d, e;
    logic [63:0] t0, t1, t2, t3, t4;
    type_state   r;
    a = s.x0 ^ s.x4;
    b = s.x1;
    c = s.x2 ^ s.x1;
    d = s.x3;
    e = s.x4 ^ s.x3;
    t0 = ~a & b;
    t1 = ~b & c;
    t2 = ~c & d;
    t3 = ~d & e;
    t4 = ~e & a;
    a = a ^ t1;
    b = b ^ t2;
    c = c ^ t3;
    d = d ^ t4;
    e = e ^ t0;
    r.x1 = b ^ a;
    r.x0 = a ^ e;
    r.x3 = d ^ c;
    r.x2 = ~c;
    r.x4 = e;
    return r;
  endfunction

  function automatic type_state pl(input type_state s);
    type_state r;
    r.x0 = s.x0 ^ ror64(s.x0, 7'd19) ^ ror64(s.x0, 7'd28);
    r.x1 = s.x1 ^ ror64(s.x1, 7'd61) ^ ror64(s.x1, 7'd39);
    r.x2 = s.x2 ^ ror64(s.x2, 7'd1)  ^ ror64(s.x2, 7'd6);
    r.x3 = s.x3 ^ ror64(s.x3, 7'd10) ^ ror64(s.x3, 7'd17);
    r.x4 = s.x4 ^ ror64(s.x4, 7'd7)  ^ ror64(s.x4, 7'd41);
    return r;
  endfunction

endpackage

// File: rtl/perm_round.sv
// One combinational Ascon round: constant addition, S-box layer, diffusion.
module perm_round
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);

  assign state_o = pl(ps(pc(state_i, round_i)));

endmodule

// File: rtl/perm_iter.sv
// Iterative Ascon permutation: one round per clock, p^a (12 rounds) or
// p^b (6 rounds), with a one-cycle done pulse and back-to-back restart.
module perm_iter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);

  perm_fsm_t  fsm_r, fsm_s;
  type_state  state_r, state_s, round_out_s;
  logic [3:0] round_r, round_s;

  perm_round u_round (
    .state_i (state_r),
    .round_i (round_r),
    .state_o (round_out_s)
  );

  // Next-state logic: load on start, iterate in RUN, hold otherwise.
  always_comb begin
    fsm_s   = fsm_r;
    state_s = state_r;
    round_s = round_r;
    case (fsm_r)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          fsm_s   = ST_RUN;
          state_s = state_i;
          round_s = mode_i ? ROUND_FIRST_B : ROUND_FIRST_A;
        end else begin
          fsm_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        state_s = round_out_s;
        // Counter parks at the last round so it never leaves 0..11.
        if (round_r >= ROUND_LAST) begin
          fsm_s = ST_DONE;
        end else begin
          round_s = round_r + 4'd1;
        end
      end
      default: begin
        fsm_s = ST_IDLE;
      end
    endcase
  end

  // State, round counter and FSM registers with synchronous reset.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fsm_r   <= ST_IDLE;
      state_r <= '0;
      round_r <= 4'd0;
    end else begin
      fsm_r   <= fsm_s;
      state_r <= state_s;
      round_r <= round_s;
    end
  end

  assign state_o = state_r;
  assign round_o = round_r;
  assign busy_o  = (fsm_r == ST_RUN);
  assign done_o  = (fsm_r == ST_DONE);

endmodule

// File: tb/tb_perm_iter.sv
// Directed self-checking bench for perm_iter against a table-driven
// bit-column Ascon reference model.
module tb_perm_iter;
  import ascon_pack::*;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       mode_i;
  type_state  state_i;
  type_state  state_o;
  logic [3:0] round_o;
  logic       busy_o;
  logic       done_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] rc_tab [12] = '{8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
                              8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};
  logic [4:0] sbox_tab [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  localparam type_state VEC = {64'h80400c0600000000, 64'h0001020304050607,
                               64'h08090a0b0c0d0e0f, 64'h0011223344556677,
                               64'h8899aabbccddeeff};
  localparam type_state ALT = {64'h0123456789abcdef, 64'hfedcba9876543210,
                               64'h0000000000000000, 64'hffffffffffffffff,
                               64'hdeadbeefcafef00d};

  perm_iter dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .mode_i  (mode_i),
    .state_i (state_i),
    .state_o (state_o),
    .round_o (round_o),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
    logic [127:0] d;
    d = {v, v} >> n;
    return d[63:0];
  endfunction

  function automatic type_state model(input type_state s, input int first);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col, o;
    type_state   r;
    x[0] = s.x0; x[1] = s.x1; x[2] = s.x2; x[3] = s.x3; x[4] = s.x4;
    for (int rr = first; rr < 12; rr++) begin
      x[2] = x[2] ^ {56'd0, rc_tab[rr[3:0]]};
      for (int b = 0; b < 64; b++) begin
        col  = {x[0][0], x[1][0], x[2][0], x[3][0], x[4][0]};
        o    = sbox_tab[col];
        y[0] = {o[4], y[0][63:1]};
        y[1] = {o[3], y[1][63:1]};
        y[2] = {o[2], y[2][63:1]};
        y[3] = {o[1], y[3][63:1]};
        y[4] = {o[0], y[4][63:1]};
        for (int i = 0; i < 5; i++) x[i] = x[i] >> 1;
      end
      x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
      x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
      x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
      x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
      x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
    end
    r.x0 = x[0]; r.x1 = x[1]; r.x2 = x[2]; r.x3 = x[3]; r.x4 = x[4];
    return r;
  endfunction

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk_s(input string tag, input type_state got, input type_state exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_r(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // Start edge, then confirm the load; inputs are scrambled afterwards.
  task automatic start_op(input logic m, input type_state din);
    logic [3:0] first;
    first   = m ? 4'd6 : 4'd0;
    start_i = 1'b1;
    mode_i  = m;
    state_i = din;
    tick();
    start_i = 1'b0;
    mode_i  = ~m;
    state_i = ~din;
    chk_s("load_state", state_o, din);
    chk_r("load_round", round_o, first);
    chk_b("load_busy", busy_o, 1'b1);
    chk_b("load_done", done_o, 1'b0);
  endtask

  // Run the remaining edges to DONE; optionally poke start at round 3.
  task automatic finish_op(input logic m, input type_state din, input bit poke);
    int         first;
    int         n;
    type_state  exp;
    logic [3:0] er;
    first = m ? 6 : 0;
    n     = 12 - first;
    exp   = model(din, first);
    for (int k = 1; k <= n; k++) begin
      tick();
      start_i = 1'b0;
      if (k < n) begin
        er = 4'(first + k);
        chk_r("run_round", round_o, er);
        chk_b("run_busy", busy_o, 1'b1);
        chk_b("run_done", done_o, 1'b0);
        if (poke && round_o == 4'd3) begin
          start_i = 1'b1;
          mode_i  = 1'b1;
          state_i = ALT;
        end
      end else begin
        chk_b("done_pulse", done_o, 1'b1);
        chk_b("done_busy", busy_o, 1'b0);
        chk_r("done_round", round_o, 4'd11);
        chk_s(m ? "result_pb" : "result_pa", state_o, exp);
      end
    end
  endtask

  task automatic idle_after(input type_state exp);
    start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk_b("idle_done", done_o, 1'b0);
      chk_b("idle_busy", busy_o, 1'b0);
      chk_s("idle_hold", state_o, exp);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    start_i = 1'b1;
    mode_i  = 1'b0;
    state_i = VEC;

    // Reset for two cycles with start held high.
    tick();
    tick();
    chk_s("rst_state", state_o, '0);
    chk_r("rst_round", round_o, 4'd0);
    chk_b("rst_busy", busy_o, 1'b0);
    chk_b("rst_done", done_o, 1'b0);
    reset_i = 1'b0;
    start_i = 1'b0;
    tick();
    chk_b("rst_idle_busy", busy_o, 1'b0);
    chk_s("rst_idle_state", state_o, '0);

    // p^a on the reference vector.
    start_op(1'b0, VEC);
    finish_op(1'b0, VEC, 1'b0);
    idle_after(model(VEC, 0));

    // p^b on the same vector.
    start_op(1'b1, VEC);
    finish_op(1'b1, VEC, 1'b0);
    idle_after(model(VEC, 6));

    // p^a with a stray start at round 3, then back-to-back p^b from DONE.
    start_op(1'b0, VEC);
    finish_op(1'b0, VEC, 1'b1);
    start_op(1'b1, ALT);
    finish_op(1'b1, ALT, 1'b0);
    idle_after(model(ALT, 6));

    // Reset at round 5 of p^a discards the run.
    start_op(1'b0, VEC);
    for (int k = 1; k <= 5; k++) tick();
    chk_r("pre_rst_round", round_o, 4'd5);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk_b("mid_rst_busy", busy_o, 1'b0);
    chk_b("mid_rst_done", done_o, 1'b0);
    chk_s("mid_rst_state", state_o, '0);
    chk_r("mid_rst_round", round_o, 4'd0);
    for (int k = 0; k < 14; k++) begin
      tick();
      chk_b("no_done_after_rst", done_o, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
